// File: rtl/rv_inst_encoder.sv
// rv_inst_encoder: packs RV32I instruction fields into a 32-bit word.
// The encoded word and its instruction-memory byte address go out through
// a one-entry output register with a valid/ready handshake.
// Optional feature macro: ENC_RANGE_CHECK_EN. When it is defined, out_err
// flags immediates that the selected format cannot represent.
module rv_inst_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        out_illegal,
  output logic        out_err,
  output logic [15:0] out_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t      state;
  logic [31:0] addr_cnt;
  logic [31:0] enc_inst;
  logic        enc_illegal;
  logic        enc_err;
  logic        is_shift;
  logic        accept;
  logic        out_hs;

  // Shift-immediate forms reuse funct7 as the top bits and carry a 5-bit shamt.
  assign is_shift = (in_opcode == OP_IMM) && ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));

  assign in_ready  = (state == EMPTY) || out_ready;
  assign out_valid = (state == FULL);
  assign accept    = in_valid && in_ready;
  assign out_hs    = (state == FULL) && out_ready;

  // Field packing per instruction format; unknown opcodes become a NOP.
  always_comb begin
    enc_inst    = 32'h0000_0000;
    enc_illegal = 1'b0;
    case (in_opcode)
      OP_R:
        enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      OP_LOAD, OP_IMM, OP_JALR: begin
        if (is_shift)
          enc_inst = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
        else
          enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      OP_STORE:
        enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      OP_BRANCH:
        enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
      OP_LUI, OP_AUIPC:
        enc_inst = {in_imm[31:12], in_rd, in_opcode};
      OP_JAL:
        enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      default: begin
        enc_inst    = 32'h0000_0013;
        enc_illegal = 1'b1;
      end
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // A signed value fits in N bits when all bits from N-1 upward agree.
  logic fit12;
  logic fit13;
  logic fit21;
  assign fit12 = (&in_imm[31:11]) || ~(|in_imm[31:11]);
  assign fit13 = (&in_imm[31:12]) || ~(|in_imm[31:12]);
  assign fit21 = (&in_imm[31:20]) || ~(|in_imm[31:20]);

  // Flag immediates whose dropped bits would change the encoded value.
  always_comb begin
    enc_err = 1'b0;
    case (in_opcode)
      OP_LOAD, OP_IMM, OP_JALR: enc_err = is_shift ? (|in_imm[31:5]) : !fit12;
      OP_STORE:                 enc_err = !fit12;
      OP_BRANCH:                enc_err = !fit13 || in_imm[0];
      OP_LUI, OP_AUIPC:         enc_err = |in_imm[11:0];
      OP_JAL:                   enc_err = !fit21 || in_imm[0];
      default:                  enc_err = 1'b0;
    endcase
  end
`else
  assign enc_err = 1'b0;
`endif

  // Output register FSM with address and word counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      out_inst    <= 32'h0000_0000;
      out_addr    <= 32'h0000_0000;
      out_illegal <= 1'b0;
      out_err     <= 1'b0;
      out_count   <= 16'h0000;
      addr_cnt    <= 32'h0000_0000;
    end else begin
      if (out_hs) begin
        addr_cnt  <= addr_cnt + 32'd4;
        out_count <= out_count + 16'd1;
      end
      if (accept) begin
        state       <= FULL;
        out_inst    <= enc_inst;
        out_illegal <= enc_illegal;
        out_err     <= enc_err;
        // A word emitted this same cycle bumps the counter first.
        out_addr    <= out_hs ? (addr_cnt + 32'd4) : addr_cnt;
      end else if (out_hs) begin
        state <= EMPTY;
      end
      // Rebasing is only safe when nothing is held or arriving.
      if (start && (state == EMPTY) && !in_valid) begin
        addr_cnt  <= base_addr;
        out_count <= 16'h0000;
      end
    end
  end

endmodule

// File: tb/tb_rv_inst_encoder.sv
// Directed bench for rv_inst_encoder: hand-encoded RV32I words.
module tb_rv_inst_encoder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_illegal;
  logic        out_err;
  logic [15:0] out_count;

  int errors = 0;
  int checks = 0;

`ifdef ENC_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  rv_inst_encoder dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr),
    .out_illegal(out_illegal), .out_err(out_err), .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm);
    in_valid  = 1'b1;
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
  endtask

  task automatic pulse_start(input logic [31:0] base);
    in_valid  = 1'b0;
    start     = 1'b1;
    base_addr = base;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0; base_addr = 32'h0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = 7'h0; in_rd = 5'h0; in_rs1 = 5'h0; in_rs2 = 5'h0;
    in_funct3 = 3'h0; in_funct7 = 7'h0; in_imm = 32'h0;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_inst !== 32'h0 ||
        out_addr !== 32'h0 || out_count !== 16'h0 || out_illegal !== 1'b0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b ready=%b inst=%h addr=%h count=%0d ill=%b err=%b, want 0 1 0 0 0 0 0",
               out_valid, in_ready, out_inst, out_addr, out_count, out_illegal, out_err);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
    end
    $display("reset: released");
  endtask

  task automatic test_addi();
    pulse_start(32'h0000_1000);
    out_ready = 1'b0;
    drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_inst !== 32'h0050_0093 || out_addr !== 32'h0000_1000 ||
        out_illegal !== 1'b0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL addi: valid=%b inst=%h addr=%h ill=%b err=%b, want 1 00500093 00001000 0 0",
               out_valid, out_inst, out_addr, out_illegal, out_err);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL addi_ready: in_ready=%b want 0", in_ready);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_count !== 16'd1) begin
      errors++;
      $display("FAIL addi_drain: valid=%b count=%0d want 0 1", out_valid, out_count);
    end
    $display("addi: inst=%h addr=%h", 32'h0050_0093, 32'h0000_1000);
  endtask

  task automatic test_back_to_back();
    pulse_start(32'h0000_2000);
    out_ready = 1'b1;
    drive(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_inst !== 32'h0020_A423 || out_addr !== 32'h0000_2000) begin
      errors++;
      $display("FAIL b2b_sw: valid=%b inst=%h addr=%h want 1 0020a423 00002000",
               out_valid, out_inst, out_addr);
    end
    drive(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_inst !== 32'h0010_00EF || out_addr !== 32'h0000_2004 ||
        out_count !== 16'd1) begin
      errors++;
      $display("FAIL b2b_jal: valid=%b inst=%h addr=%h count=%0d want 1 001000ef 00002004 1",
               out_valid, out_inst, out_addr, out_count);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_count !== 16'd2) begin
      errors++;
      $display("FAIL b2b_count: valid=%b count=%0d want 0 2", out_valid, out_count);
    end
    $display("back_to_back: sw@2000 jal@2004 count=2");
  endtask

  task automatic test_imm_err();
    out_ready = 1'b0;
    drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_inst !== 32'h8000_0093 || out_err !== RC || out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL imm_err: inst=%h err=%b ill=%b want 80000093 %b 0",
               out_inst, out_err, out_illegal, RC);
    end
    out_ready = 1'b1;
    tick();
    $display("imm_err: addi 2048 err=%b", RC);
  endtask

  task automatic test_formats();
    logic [6:0]  op  [6];
    logic [4:0]  rd  [6];
    logic [4:0]  rs1 [6];
    logic [4:0]  rs2 [6];
    logic [2:0]  f3  [6];
    logic [6:0]  f7  [6];
    logic [31:0] imm [6];
    logic [31:0] exp_inst [6];
    logic        exp_err  [6];
    // add x3,x1,x2
    op[0]=7'b0110011; rd[0]=5'd3; rs1[0]=5'd1; rs2[0]=5'd2; f3[0]=3'b000; f7[0]=7'd0;  imm[0]=32'd0;
    exp_inst[0]=32'h0020_81B3; exp_err[0]=1'b0;
    // beq x1,x2,-4
    op[1]=7'b1100011; rd[1]=5'd0; rs1[1]=5'd1; rs2[1]=5'd2; f3[1]=3'b000; f7[1]=7'd0;  imm[1]=32'hFFFF_FFFC;
    exp_inst[1]=32'hFE20_8EE3; exp_err[1]=1'b0;
    // lui x5,0x12345
    op[2]=7'b0110111; rd[2]=5'd5; rs1[2]=5'd0; rs2[2]=5'd0; f3[2]=3'b000; f7[2]=7'd0;  imm[2]=32'h1234_5000;
    exp_inst[2]=32'h1234_52B7; exp_err[2]=1'b0;
    // slli x6,x7,3
    op[3]=7'b0010011; rd[3]=5'd6; rs1[3]=5'd7; rs2[3]=5'd0; f3[3]=3'b001; f7[3]=7'd0;  imm[3]=32'd3;
    exp_inst[3]=32'h0033_9313; exp_err[3]=1'b0;
    // srai x6,x7,3
    op[4]=7'b0010011; rd[4]=5'd6; rs1[4]=5'd7; rs2[4]=5'd0; f3[4]=3'b101; f7[4]=7'h20; imm[4]=32'd3;
    exp_inst[4]=32'h4033_D313; exp_err[4]=1'b0;
    // beq x1,x2,-3 : odd offset, bit 0 dropped
    op[5]=7'b1100011; rd[5]=5'd0; rs1[5]=5'd1; rs2[5]=5'd2; f3[5]=3'b000; f7[5]=7'd0;  imm[5]=32'hFFFF_FFFD;
    exp_inst[5]=32'hFE20_8EE3; exp_err[5]=RC;

    pulse_start(32'h0000_4000);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(op[i], rd[i], rs1[i], rs2[i], f3[i], f7[i], imm[i]);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_inst !== exp_inst[i] || out_err !== exp_err[i] ||
          out_addr !== (32'h0000_4000 + 32'(4 * i))) begin
        errors++;
        $display("FAIL format_%0d: valid=%b inst=%h err=%b addr=%h want 1 %h %b %h", i,
                 out_valid, out_inst, out_err, out_addr, exp_inst[i], exp_err[i],
                 32'h0000_4000 + 32'(4 * i));
      end
      $display("format_%0d: inst=%h addr=%h", i, exp_inst[i], 32'h0000_4000 + 32'(4 * i));
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_count !== 16'd6) begin
      errors++;
      $display("FAIL format_count: valid=%b count=%0d want 0 6", out_valid, out_count);
    end
  endtask

  task automatic test_stall();
    pulse_start(32'h0000_3000);
    out_ready = 1'b0;
    drive(7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1);
    tick();
    drive(7'b0010011, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_inst !== 32'h0010_0113 ||
          out_addr !== 32'h0000_3000 || out_count !== 16'd0) begin
        errors++;
        $display("FAIL stall_%0d: ready=%b valid=%b inst=%h addr=%h count=%0d want 0 1 00100113 00003000 0",
                 c, in_ready, out_valid, out_inst, out_addr, out_count);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_inst !== 32'h0020_0193 || out_addr !== 32'h0000_3004 ||
        out_count !== 16'd1) begin
      errors++;
      $display("FAIL stall_release: valid=%b inst=%h addr=%h count=%0d want 1 00200193 00003004 1",
               out_valid, out_inst, out_addr, out_count);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_count !== 16'd2) begin
      errors++;
      $display("FAIL stall_drain: valid=%b count=%0d want 0 2", out_valid, out_count);
    end
    $display("stall: held 3 cycles, two words emitted");
  endtask

  task automatic test_illegal_and_reset();
    out_ready = 1'b0;
    drive(7'b1111111, 5'd5, 5'd1, 5'd2, 3'b000, 7'd0, 32'hFFFF_FFFF);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_inst !== 32'h0000_0013 || out_illegal !== 1'b1 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL illegal: valid=%b inst=%h ill=%b err=%b want 1 00000013 1 0",
               out_valid, out_inst, out_illegal, out_err);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_count !== 16'd0 || in_ready !== 1'b1 ||
        out_inst !== 32'h0 || out_addr !== 32'h0 || out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b count=%0d ready=%b inst=%h addr=%h ill=%b want 0 0 1 0 0 0",
               out_valid, out_count, in_ready, out_inst, out_addr, out_illegal);
    end
    tick();
    rst = 1'b0;
    tick();
    $display("illegal: nop emitted, async reset cleared held word");
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_imm_err();
    test_formats();
    test_stall();
    test_illegal_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
